// File: rtl/sys_types.sv
// Shared types for the convolution tile sequencer: state encoding and array geometry.
package sys_types;

  localparam int SA_N  = 4;  // systolic array edge, also the output tile edge
  localparam int VEC_W = 4;  // input channels carried by one PE vector

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/window_mask_gen.sv
// Combinational in-bounds mask for SA_N consecutive positions starting at a signed base.
module window_mask_gen #(
  parameter int SA_N    = 4,
  parameter int BASE_W  = 11,
  parameter int BOUND_W = 16
) (
  input  logic signed [BASE_W-1:0]  base,
  input  logic        [BOUND_W-1:0] bound,
  output logic        [SA_N-1:0]    mask
);
  import sys_types::*;

  // Wide enough to hold base+SA_N and the unsigned bound without wrap.
  localparam int EXT_W = ((BASE_W > BOUND_W) ? BASE_W : BOUND_W) + 2;

  logic signed [EXT_W-1:0] bound_ext;
  logic signed [EXT_W-1:0] base_ext;

  assign bound_ext = $signed({{(EXT_W-BOUND_W){1'b0}}, bound});
  assign base_ext  = $signed({{(EXT_W-BASE_W){base[BASE_W-1]}}, base});

  // One comparator pair per lane: inside when 0 <= base+i < bound.
  generate
    for (genvar gi = 0; gi < SA_N; gi++) begin : g_lane
      logic signed [EXT_W-1:0] pos;
      assign pos      = base_ext + $signed(EXT_W'(gi));
      assign mask[gi] = !pos[EXT_W-1] && (pos < bound_ext);
    end
  endgenerate

endmodule

// File: rtl/conv_tile_sequencer.sv
// Walks kernel rows, kernel columns and channel groups of one output tile,
// issuing one registered window request per reduction point.
module conv_tile_sequencer #(
  parameter int MAX_NUM_CH = 64,
  parameter int MAX_N      = 512,
  parameter int SA_N       = 4,
  parameter int VEC_W      = 4,
  parameter int K          = 3,
  parameter int PAD        = 1,
  parameter int WADDR_W    = 16,
  localparam int POS_W     = $clog2(MAX_N),
  localparam int CH_W      = $clog2(MAX_NUM_CH),
  localparam int NCH_W     = $clog2(MAX_NUM_CH + 1),
  localparam int CG_W      = $clog2(MAX_NUM_CH / VEC_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reset_sta,
  input  logic                     start_compute,
  input  logic [POS_W-1:0]         controller_pos_row,
  input  logic [POS_W-1:0]         controller_pos_col,
  input  logic [CH_W-1:0]          chnnl_idx,
  input  logic [NCH_W-1:0]         num_input_channels,
  input  logic [15:0]              in_h,
  input  logic [15:0]              in_w,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic signed [POS_W:0]    req_row,
  output logic signed [POS_W:0]    req_col,
  output logic [CG_W-1:0]          req_cg,
  output logic [SA_N-1:0]          req_row_mask,
  output logic [SA_N-1:0]          req_col_mask,
  output logic [WADDR_W-1:0]       req_waddr,
  output logic                     req_last,
  output logic                     done
);
  import sys_types::*;

  localparam int KC_W   = (K > 1) ? $clog2(K) : 1;
  localparam int NCG_W  = CG_W + 1;
  // One extra bit over the request width so pos+K-1-PAD never wraps internally.
  localparam int BASE_W = POS_W + 2;

  seq_state_t state_q, state_d;

  logic [KC_W-1:0]    kr_q, kr_d, kc_q, kc_d;
  logic [CG_W-1:0]    cg_q, cg_d;
  logic [NCG_W-1:0]   ncg_q, ncg_d;
  logic [POS_W-1:0]   pos_row_q, pos_row_d, pos_col_q, pos_col_d;
  logic [15:0]        in_h_q, in_h_d, in_w_q, in_w_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;

  logic signed [POS_W:0] req_row_q, req_row_d, req_col_q, req_col_d;
  logic [CG_W-1:0]       req_cg_q, req_cg_d;
  logic [SA_N-1:0]       row_mask_q, row_mask_d, col_mask_q, col_mask_d;
  logic                  req_last_q, req_last_d;

  logic load_en;   // a new reduction point is presented on the next edge
  logic clear_en;  // per-tile clear requested

  // Channel-group count and weight base are only computed at tile start.
  logic [NCH_W:0]     ch_round;
  logic [NCH_W:0]     ncg_div;
  logic [NCG_W-1:0]   ncg_start;
  logic [WADDR_W-1:0] waddr_base;

  assign ch_round   = {1'b0, num_input_channels} + (NCH_W+1)'(VEC_W - 1);
  assign ncg_div    = ch_round / (NCH_W+1)'(VEC_W);
  assign ncg_start  = (ncg_div == '0) ? NCG_W'(1) : NCG_W'(ncg_div);
  assign waddr_base = WADDR_W'(chnnl_idx) * WADDR_W'(K * K) * WADDR_W'(ncg_start);

  // Window origin of the point being loaded, in input coordinates.
  logic signed [BASE_W-1:0] row_base_d, col_base_d;
  logic [SA_N-1:0]          row_mask_calc, col_mask_calc;
  logic                     is_last_d;

  assign row_base_d = $signed({2'b00, pos_row_d}) + $signed(BASE_W'(kr_d)) - $signed(BASE_W'(PAD));
  assign col_base_d = $signed({2'b00, pos_col_d}) + $signed(BASE_W'(kc_d)) - $signed(BASE_W'(PAD));
  assign is_last_d  = (kr_d == KC_W'(K - 1)) && (kc_d == KC_W'(K - 1)) &&
                      ({1'b0, cg_d} == (ncg_d - NCG_W'(1)));

  window_mask_gen #(.SA_N(SA_N), .BASE_W(BASE_W), .BOUND_W(16)) u_row_mask (
    .base  (row_base_d),
    .bound (in_h_d),
    .mask  (row_mask_calc)
  );

  window_mask_gen #(.SA_N(SA_N), .BASE_W(BASE_W), .BOUND_W(16)) u_col_mask (
    .base  (col_base_d),
    .bound (in_w_d),
    .mask  (col_mask_calc)
  );

  // Next-state, loop counters and latched tile context; cg innermost, then kc, then kr.
  always_comb begin
    state_d   = state_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    cg_d      = cg_q;
    ncg_d     = ncg_q;
    pos_row_d = pos_row_q;
    pos_col_d = pos_col_q;
    in_h_d    = in_h_q;
    in_w_d    = in_w_q;
    waddr_d   = waddr_q;
    load_en   = 1'b0;
    clear_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_compute) begin
          state_d   = S_ISSUE;
          pos_row_d = controller_pos_row;
          pos_col_d = controller_pos_col;
          in_h_d    = in_h;
          in_w_d    = in_w;
          ncg_d     = ncg_start;
          kr_d      = '0;
          kc_d      = '0;
          cg_d      = '0;
          waddr_d   = waddr_base;
          load_en   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          if (req_last_q) begin
            state_d = S_DONE;
          end else begin
            load_en = 1'b1;
            waddr_d = waddr_q + WADDR_W'(1);
            if (({1'b0, cg_q} + NCG_W'(1)) == ncg_q) begin
              cg_d = '0;
              if (kc_q == KC_W'(K - 1)) begin
                kc_d = '0;
                kr_d = kr_q + KC_W'(1);
              end else begin
                kc_d = kc_q + KC_W'(1);
              end
            end else begin
              cg_d = cg_q + CG_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A per-tile clear beats any concurrent transfer; that request is dropped.
    if (reset_sta) begin
      state_d  = S_IDLE;
      kr_d     = '0;
      kc_d     = '0;
      cg_d     = '0;
      waddr_d  = '0;
      load_en  = 1'b0;
      clear_en = 1'b1;
    end
  end

  // Request fields: refresh only when a new point is loaded so they hold under backpressure.
  always_comb begin
    req_row_d  = req_row_q;
    req_col_d  = req_col_q;
    req_cg_d   = req_cg_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    if (clear_en) begin
      req_row_d  = '0;
      req_col_d  = '0;
      req_cg_d   = '0;
      row_mask_d = '0;
      col_mask_d = '0;
    end else if (load_en) begin
      req_row_d  = $signed(row_base_d[POS_W:0]);
      req_col_d  = $signed(col_base_d[POS_W:0]);
      req_cg_d   = cg_d;
      row_mask_d = row_mask_calc;
      col_mask_d = col_mask_calc;
    end
    req_last_d = (state_d == S_ISSUE) && (load_en ? is_last_d : req_last_q);
  end

  // State, counters, latched context and registered request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kr_q       <= '0;
      kc_q       <= '0;
      cg_q       <= '0;
      ncg_q      <= '0;
      pos_row_q  <= '0;
      pos_col_q  <= '0;
      in_h_q     <= '0;
      in_w_q     <= '0;
      waddr_q    <= '0;
      req_row_q  <= '0;
      req_col_q  <= '0;
      req_cg_q   <= '0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      req_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      cg_q       <= cg_d;
      ncg_q      <= ncg_d;
      pos_row_q  <= pos_row_d;
      pos_col_q  <= pos_col_d;
      in_h_q     <= in_h_d;
      in_w_q     <= in_w_d;
      waddr_q    <= waddr_d;
      req_row_q  <= req_row_d;
      req_col_q  <= req_col_d;
      req_cg_q   <= req_cg_d;
      row_mask_q <= row_mask_d;
      col_mask_q <= col_mask_d;
      req_last_q <= req_last_d;
    end
  end

  assign req_valid    = (state_q == S_ISSUE);
  assign done         = (state_q == S_DONE);
  assign req_row      = req_row_q;
  assign req_col      = req_col_q;
  assign req_cg       = req_cg_q;
  assign req_row_mask = row_mask_q;
  assign req_col_mask = col_mask_q;
  assign req_waddr    = waddr_q;
  assign req_last     = req_last_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed bench for conv_tile_sequencer with a request scoreboard.
module tb_conv_tile_sequencer;

  logic        clk = 1'b0;
  logic        reset, reset_sta, start_compute, req_ready;
  logic [8:0]  controller_pos_row, controller_pos_col;
  logic [5:0]  chnnl_idx;
  logic [6:0]  num_input_channels;
  logic [15:0] in_h, in_w;
  logic        req_valid, req_last, done;
  logic signed [9:0] req_row, req_col;
  logic [3:0]  req_cg, req_row_mask, req_col_mask;
  logic [15:0] req_waddr;

  always #5 clk = ~clk;

  conv_tile_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .reset_sta          (reset_sta),
    .start_compute      (start_compute),
    .controller_pos_row (controller_pos_row),
    .controller_pos_col (controller_pos_col),
    .chnnl_idx          (chnnl_idx),
    .num_input_channels (num_input_channels),
    .in_h               (in_h),
    .in_w               (in_w),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_row            (req_row),
    .req_col            (req_col),
    .req_cg             (req_cg),
    .req_row_mask       (req_row_mask),
    .req_col_mask       (req_col_mask),
    .req_waddr          (req_waddr),
    .req_last           (req_last),
    .done               (done)
  );

  typedef struct packed {
    logic signed [9:0] row;
    logic signed [9:0] col;
    logic [3:0]        cg;
    logic [3:0]        rm;
    logic [3:0]        cm;
    logic [15:0]       waddr;
    logic              last;
  } req_t;

  req_t exp_q[$];
  req_t obs;
  int   checks = 0;
  int   failures = 0;
  int   xfer_cnt = 0;

  assign obs = {req_row, req_col, req_cg, req_row_mask, req_col_mask, req_waddr, req_last};

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected request stream for one tile (K=3, PAD=1, VEC_W=4).
  task automatic push_tile(input int pr, input int pc, input int ch, input int cin,
                           input int h, input int w);
    int   ncg, base, total, n, r, c;
    req_t e;
    ncg = (cin + 3) / 4;
    if (ncg == 0) ncg = 1;
    total = 9 * ncg;
    base  = ch * 9 * ncg;
    n     = 0;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        for (int cg = 0; cg < ncg; cg++) begin
          r       = pr + kr - 1;
          c       = pc + kc - 1;
          e.row   = 10'(r);
          e.col   = 10'(c);
          e.cg    = 4'(cg);
          for (int i = 0; i < 4; i++) begin
            e.rm[i] = (r + i >= 0) && (r + i < h);
            e.cm[i] = (c + i >= 0) && (c + i < w);
          end
          e.waddr = 16'(base + n);
          e.last  = (n == total - 1);
          exp_q.push_back(e);
          n++;
        end
      end
    end
  endtask

  task automatic score();
    req_t e;
    xfer_cnt++;
    $display("xfer %0d row=%0d col=%0d cg=%0d rmask=%b cmask=%b waddr=%0d last=%0b",
             xfer_cnt, req_row, req_col, req_cg, req_row_mask, req_col_mask, req_waddr, req_last);
    check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("req_fields", 64'(obs), 64'(e));
    end
  endtask

  // One clock: score a transfer at the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (req_valid && req_ready) score();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int exp_valid, input string tag);
    int vcyc = 0;
    bit seen = 1'b0;
    bit prev_last_xfer = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (req_valid) vcyc++;
      prev_last_xfer = req_valid && req_ready && req_last;
      step();
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_done_latency"}, 64'(prev_last_xfer), 64'd1);
    check({tag, "_valid_in_done"}, 64'(req_valid), 64'd0);
    if (exp_valid >= 0) check({tag, "_valid_cycles"}, 64'(vcyc), 64'(exp_valid));
    check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_tile(input string tag);
    reset_sta = 1'b1;
    step();
    reset_sta = 1'b0;
    check({tag, "_clr_done"}, 64'(done), 64'd0);
    check({tag, "_clr_valid"}, 64'(req_valid), 64'd0);
  endtask

  task automatic run_xfers(input int n, input string tag);
    int b;
    b = xfer_cnt;
    for (int i = 0; i < 200 && (xfer_cnt - b) < n; i++) step();
    check({tag, "_reach"}, 64'(xfer_cnt - b), 64'(n));
  endtask

  task automatic set_tile(input int pr, input int pc, input int ch, input int cin);
    controller_pos_row = 9'(pr);
    controller_pos_col = 9'(pc);
    chnnl_idx          = 6'(ch);
    num_input_channels = 7'(cin);
  endtask

  initial begin
    int b0;
    reset = 1'b1; reset_sta = 1'b0; start_compute = 1'b0; req_ready = 1'b1;
    in_h = 16'd8; in_w = 16'd8;
    set_tile(0, 0, 0, 0);
    repeat (3) step();
    check("rst_valid", 64'(req_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_last", 64'(req_last), 64'd0);
    check("rst_waddr", 64'(req_waddr), 64'd0);
    check("rst_row", 64'(req_row), 64'd0);
    check("rst_masks", 64'({req_row_mask, req_col_mask, req_cg}), 64'd0);
    reset = 1'b0;
    step();
    check("idle_valid", 64'(req_valid), 64'd0);

    // Full tile, no stalls; inputs disturbed mid-tile, start held through DONE.
    set_tile(4, 4, 2, 16);
    push_tile(4, 4, 2, 16, 8, 8);
    start_compute = 1'b1;
    step();
    check("t1_first_valid", 64'(req_valid), 64'd1);
    check("t1_first_row", 64'(req_row), 64'd3);
    check("t1_first_col", 64'(req_col), 64'd3);
    check("t1_first_waddr", 64'(req_waddr), 64'd72);
    check("t1_first_cg", 64'(req_cg), 64'd0);
    set_tile(100, 200, 7, 4);
    in_h = 16'd2;
    wait_done(36, "t1");
    in_h = 16'd8;
    repeat (3) step();
    check("t1_done_hold", 64'(done), 64'd1);
    start_compute = 1'b0;
    clear_tile("t1");

    // Top/left padding with backpressure mid-tile.
    set_tile(0, 0, 2, 16);
    push_tile(0, 0, 2, 16, 8, 8);
    b0 = xfer_cnt;
    start_compute = 1'b1;
    step();
    start_compute = 1'b0;
    check("t2_row_neg", 64'(req_row), -64'sd1);
    check("t2_col_neg", 64'(req_col), -64'sd1);
    check("t2_masks", 64'({req_row_mask, req_col_mask}), 64'h EE);
    run_xfers(10, "t2");
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_valid", 64'(req_valid), 64'd1);
      check("t2_stall_fields", 64'(obs), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'd0);
    end
    req_ready = 1'b1;
    wait_done(-1, "t2");
    check("t2_total", 64'(xfer_cnt - b0), 64'd36);
    clear_tile("t2");

    // Single channel group.
    set_tile(4, 4, 0, 1);
    push_tile(4, 4, 0, 1, 8, 8);
    start_compute = 1'b1;
    step();
    start_compute = 1'b0;
    check("t3_first_waddr", 64'(req_waddr), 64'd0);
    wait_done(9, "t3");
    clear_tile("t3");

    // Mid-tile clear coinciding with a transfer, then restart with a new base.
    set_tile(4, 0, 1, 8);
    push_tile(4, 0, 1, 8, 8, 8);
    start_compute = 1'b1;
    step();
    start_compute = 1'b0;
    run_xfers(10, "t4");
    reset_sta = 1'b1;
    step();
    reset_sta = 1'b0;
    check("t4_clr_valid", 64'(req_valid), 64'd0);
    check("t4_clr_done", 64'(done), 64'd0);
    exp_q.delete();
    step();
    check("t4_idle_hold", 64'(req_valid), 64'd0);
    set_tile(8, 4, 3, 5);
    push_tile(8, 4, 3, 5, 8, 8);
    start_compute = 1'b1;
    step();
    start_compute = 1'b0;
    check("t4_restart_waddr", 64'(req_waddr), 64'd54);
    wait_done(18, "t4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
